// File: rtl/dec_pkg.sv
// rtl/dec_pkg.sv - shared state/mode encodings and width helper for the scan decoder
package dec_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_DIR  = 2'd1,
    ST_SCAN = 2'd2
  } state_t;

  localparam logic MODE_DIRECT = 1'b0;
  localparam logic MODE_SCAN   = 1'b1;

  // Never returns less than 1 so a PRESCALE of 1 still gets a legal counter.
  function automatic int clog2(input int value);
    int w;
    w = 1;
    while ((1 << w) < value) w++;
    return w;
  endfunction

endpackage

// File: rtl/dec_core.sv
// rtl/dec_core.sv - combinational IN_W to 2**IN_W one-hot decoder with selectable polarity
module dec_core #(
  parameter int IN_W       = 2,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic [IN_W-1:0]    sel,
  input  logic               en,
  output logic [2**IN_W-1:0] dec
);

  always_comb begin
    dec = '0;
    if (en) dec[sel] = 1'b1;
    if (ACTIVE_LOW) dec = ~dec;
  end

endmodule

// File: rtl/dec_scan.sv
// rtl/dec_scan.sv - registered one-hot select driver with direct decode and prescaled scan
module dec_scan
  import dec_pkg::*;
#(
  parameter int IN_W       = 2,
  parameter int PRESCALE   = 3,
  parameter bit ACTIVE_LOW = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_en,
  input  logic               i_mode,
  input  logic [IN_W-1:0]    i_in,
  output logic [2**IN_W-1:0] o_out,
  output logic [IN_W-1:0]    o_idx,
  output logic               o_valid,
  output logic               o_wrap
);

  localparam int                OUT_W   = 2**IN_W;
  localparam int                CNT_W   = clog2(PRESCALE);
  localparam logic [CNT_W-1:0]  CNT_MAX = CNT_W'(PRESCALE - 1);
  localparam logic [IN_W-1:0]   IDX_MAX = '1;
  localparam logic [OUT_W-1:0]  OUT_OFF = {OUT_W{ACTIVE_LOW}};

  state_t           state_q, state_d;
  logic [IN_W-1:0]  idx_q, idx_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             ctx_q, ctx_d;
  logic             act_d;
  logic             wrap_d;
  logic [OUT_W-1:0] out_d;

  dec_core #(
    .IN_W       (IN_W),
    .ACTIVE_LOW (ACTIVE_LOW)
  ) u_core (
    .sel (idx_d),
    .en  (act_d),
    .dec (out_d)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= ST_IDLE;
      idx_q   <= '0;
      cnt_q   <= '0;
      ctx_q   <= 1'b0;
      o_out   <= OUT_OFF;
      o_valid <= 1'b0;
      o_wrap  <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      ctx_q   <= ctx_d;
      o_out   <= out_d;
      o_valid <= act_d;
      o_wrap  <= wrap_d;
    end
  end

  always_comb begin
    state_d = ST_IDLE;
    if (i_en) state_d = (i_mode == MODE_SCAN) ? ST_SCAN : ST_DIR;
  end

  // ctx_q marks a frozen scan that may resume; it survives IDLE only while i_mode stays SCAN.
  always_comb begin
    idx_d  = idx_q;
    cnt_d  = cnt_q;
    ctx_d  = ctx_q;
    act_d  = 1'b0;
    wrap_d = 1'b0;
    case (state_d)
      ST_IDLE: ctx_d = ctx_q & (i_mode == MODE_SCAN);
      ST_DIR: begin
        idx_d = i_in;
        cnt_d = '0;
        ctx_d = 1'b0;
        act_d = 1'b1;
      end
      ST_SCAN: begin
        act_d = 1'b1;
        ctx_d = 1'b1;
        if (state_q == ST_DIR || (state_q == ST_IDLE && !ctx_q)) begin
          idx_d = '0;
          cnt_d = '0;
        end else if (cnt_q == CNT_MAX) begin
          cnt_d  = '0;
          idx_d  = idx_q + IN_W'(1);
          wrap_d = (idx_q == IDX_MAX);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: ;
    endcase
  end

  assign o_idx = idx_q;

endmodule
